// File: rtl/axi_scratchpad_slave.sv
// AXI4 scratchpad responder: one in-flight burst, single-ported byte-lane RAM.
// Optional AXI_SCRATCH_DECERR_EN: out-of-window bursts return DECERR, no RAM writes.
module axi_scratchpad_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] aw_addr,
  input  logic [5:0]  aw_id,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_burst,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  input  logic        w_last,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [5:0]  b_id,
  output logic [1:0]  b_resp,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [31:0] ar_addr,
  input  logic [5:0]  ar_id,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_burst,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [5:0]  r_id,
  output logic [63:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_last
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t            state, state_nxt;
  logic              started;
  logic              prio;
  logic [5:0]        cur_id;
  logic [7:0]        cur_len;
  logic [2:0]        cur_size;
  logic [1:0]        cur_burst;
  logic [31:0]       cur_addr;
  logic [31:0]       next_addr;
  logic [31:0]       cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [7:0]        beat_cnt;
  logic              err;
  logic              start_err;
  logic              aw_hs, ar_hs;
  logic              wr_en, rd_en;
  logic              last_beat;

  assign aw_hs     = aw_valid && aw_ready;
  assign ar_hs     = ar_valid && ar_ready;
  assign last_beat = (beat_cnt == cur_len);
  assign next_addr = (cur_burst == 2'b00) ? cur_addr : cur_addr + (32'd1 << cur_size);
  assign cur_off   = cur_addr - BASE_ADDR;
  assign cur_idx   = cur_off[IDX_W+2:3];

  assign wr_en = (state == WDATA) && w_valid;
  // Issue a RAM read whenever the output slot is empty or being drained,
  // so r_data only moves on a handshake and beats stream back-to-back.
  assign rd_en = (state == RDATA) && (!r_valid || (r_ready && !r_last));

`ifdef AXI_SCRATCH_DECERR_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 3;

  function automatic logic out_of_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} >= SPAN;
  endfunction

  assign start_err = aw_hs ? out_of_range(aw_addr) : out_of_range(ar_addr);
`else
  assign start_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, w_last, cur_off[31:IDX_W+3], cur_off[2:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_id      = '0;
    b_resp    = '0;
    unique case (state)
      IDLE: begin
        // Readies depend on the competing valid so a conflict grants one side only.
        aw_ready = started && (!ar_valid || !prio);
        ar_ready = started && (!aw_valid || prio);
        if (aw_valid && aw_ready)      state_nxt = WDATA;
        else if (ar_valid && ar_ready) state_nxt = RDATA;
      end
      WDATA: begin
        w_ready = 1'b1;
        if (w_valid && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        b_id    = cur_id;
        b_resp  = err ? 2'b11 : 2'b00;
        if (b_ready) state_nxt = IDLE;
      end
      RDATA: begin
        if (r_valid && r_ready && r_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started   <= 1'b0;
      prio      <= 1'b0;
      cur_id    <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      cur_addr  <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      started <= 1'b1;
      if (aw_hs || ar_hs) begin
        if (aw_valid && ar_valid) prio <= !prio;
        cur_id    <= aw_hs ? aw_id    : ar_id;
        cur_len   <= aw_hs ? aw_len   : ar_len;
        cur_size  <= aw_hs ? aw_size  : ar_size;
        cur_burst <= aw_hs ? aw_burst : ar_burst;
        cur_addr  <= aw_hs ? aw_addr  : ar_addr;
        beat_cnt  <= '0;
        err       <= start_err;
      end
      if (wr_en || rd_en) begin
        cur_addr <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (rd_en) begin
        r_valid <= 1'b1;
        r_last  <= last_beat;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign r_id   = r_valid ? cur_id : '0;
  assign r_resp = (r_valid && err) ? 2'b11 : 2'b00;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic [7:0] lane [DEPTH_WORDS];
    logic [7:0] q;
    always_ff @(posedge clock) begin
      if (wr_en && !err && w_strb[g]) lane[cur_idx] <= w_data[8*g +: 8];
      if (rd_en) q <= err ? 8'h00 : lane[cur_idx];
    end
    assign r_data[8*g +: 8] = q;
  end

endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// Self-checking bench for axi_scratchpad_slave: vector table, read scoreboard,
// hand-written sequences for long bursts, mid-burst reset and AW/AR conflicts.
`timescale 1ns/1ps
module tb_axi_scratchpad_slave;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic [5:0]  aw_id = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        b_valid, b_ready = 1'b0;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic [5:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        r_valid, r_ready = 1'b0;
  logic [5:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  always #5 clock = ~clock;

  axi_scratchpad_slave #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [5:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] seed;
    bit          has_exp;
    logic [63:0] exp_first;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } beat_t;

  beat_t       sb[$];
  vec_t        tbl[15];
  logic [63:0] mem_m [4096];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
`ifdef AXI_SCRATCH_DECERR_EN
    return a >= 32'h0000_8000;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size, input int k);
    if (burst == 2'b00) return a;
    return a + 32'(k) * (32'd1 << size);
  endfunction

  function automatic logic [63:0] ctl_vec();
    return 64'({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_resp, r_resp, b_id, r_id});
  endfunction

  task automatic wait_aw();
    bit hs;
    hs = 1'b0;
    for (int n = 0; n < 200 && !hs; n++) begin
      #1 hs = aw_ready;
      @(negedge clock);
    end
    aw_valid = 1'b0;
    chk("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_ar();
    bit hs;
    hs = 1'b0;
    for (int n = 0; n < 200 && !hs; n++) begin
      #1 hs = ar_ready;
      @(negedge clock);
    end
    ar_valid = 1'b0;
    chk("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    aw_addr = a; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    ar_addr = a; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
  endtask

  task automatic w_beats(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] strb, input logic [63:0] seed);
    bit hs;
    logic [31:0] ba;
    for (int k = 0; k <= int'(len); k++) begin
      hs = 1'b0;
      w_valid = 1'b1; w_data = seed * 64'(k + 1); w_strb = strb; w_last = (k == int'(len));
      for (int n = 0; n < 50 && !hs; n++) begin
        #1 hs = w_ready;
        @(negedge clock);
      end
      chk("w_handshake", 64'(hs), 64'd1);
      if (hs && !oob(a)) begin
        ba = beat_addr(a, burst, size, k);
        for (int b = 0; b < 8; b++)
          if (strb[b]) mem_m[ba[14:3]][8*b +: 8] = w_data[8*b +: 8];
      end
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_wait(input logic [5:0] id, input logic [1:0] resp);
    bit seen;
    seen = 1'b0;
    b_ready = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      #1;
      if (b_valid) begin
        seen = 1'b1;
        chk("b_id", 64'(b_id), 64'(id));
        chk("b_resp", 64'(b_resp), 64'(resp));
      end
      @(negedge clock);
    end
    b_ready = 1'b0;
    chk("b_seen", 64'(seen), 64'd1);
  endtask

  task automatic push_read(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    beat_t e;
    logic [31:0] ba;
    sb.delete();
    for (int k = 0; k <= int'(len); k++) begin
      ba     = beat_addr(a, burst, size, k);
      e.data = oob(a) ? 64'd0 : mem_m[ba[14:3]];
      e.resp = oob(a) ? 2'b11 : 2'b00;
      e.last = (k == int'(len));
      e.id   = id;
      sb.push_back(e);
    end
  endtask

  task automatic r_collect(input logic [7:0] len, input bit toggle, input bit has_exp,
                           input logic [63:0] exp_first);
    beat_t e;
    int got, first, lastc;
    bit done;
    got = 0; first = 0; lastc = 0; done = 1'b0;
    for (int i = 1; i < 2000 && !done; i++) begin
      r_ready = toggle ? (i % 2 == 0) : 1'b1;
      #1;
      if (r_valid) begin
        if (first == 0) first = i;
        if (sb.size() == 0) begin
          chk("r_extra_beat", 64'(r_valid), 64'd0);
        end else begin
          e = sb[0];
          chk("r_data", r_data, e.data);
          chk("r_resp", 64'(r_resp), 64'(e.resp));
          chk("r_last", 64'(r_last), 64'(e.last));
          chk("r_id", 64'(r_id), 64'(e.id));
          if (r_ready) begin
            if (got == 0 && has_exp) chk("r_first", r_data, exp_first);
            void'(sb.pop_front());
            got++;
            if (e.last) begin done = 1'b1; lastc = i; end
          end
        end
      end
      @(negedge clock);
    end
    r_ready = 1'b0;
    chk("r_beats", 64'(got), 64'(int'(len) + 1));
    chk("r_latency", 64'(first), 64'd2);
    if (!toggle) chk("r_span", 64'(lastc - first + 1), 64'(int'(len) + 1));
  endtask

  task automatic do_write(input vec_t v);
    set_aw(v.addr, v.id, v.len, v.size, v.burst);
    wait_aw();
    w_beats(v.addr, v.len, v.size, v.burst, v.strb, v.seed);
    b_wait(v.id, oob(v.addr) ? 2'b11 : 2'b00);
  endtask

  task automatic do_read(input vec_t v, input bit toggle);
    set_ar(v.addr, v.id, v.len, v.size, v.burst);
    push_read(v.addr, v.id, v.len, v.size, v.burst);
    wait_ar();
    r_collect(v.len, toggle, v.has_exp, v.exp_first);
  endtask

  initial begin
    vec_t v;
    bit   any_b;
    //          wr    addr           id     len    sz    burst  strb   seed                    has  exp_first
    tbl[0]  = '{1'b1, 32'h0000_0040, 6'd5,  8'd3,  3'd3, 2'b01, 8'hFF, 64'h11,                 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 32'h0000_0040, 6'd5,  8'd3,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'h11};
    tbl[2]  = '{1'b1, 32'h0000_0000, 6'd1,  8'd1,  3'd3, 2'b01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    tbl[3]  = '{1'b1, 32'h0000_0000, 6'd2,  8'd0,  3'd3, 2'b01, 8'h0F, 64'h0,                  1'b0, 64'h0};
    tbl[4]  = '{1'b0, 32'h0000_0000, 6'd3,  8'd0,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'hFFFF_FFFF_0000_0000};
    tbl[5]  = '{1'b1, 32'h0000_0100, 6'd7,  8'd2,  3'd3, 2'b00, 8'hFF, 64'h1234,               1'b0, 64'h0};
    tbl[6]  = '{1'b0, 32'h0000_0100, 6'd8,  8'd1,  3'd3, 2'b00, 8'h00, 64'h0,                  1'b1, 64'h369C};
    tbl[7]  = '{1'b1, 32'h0000_0200, 6'd9,  8'd3,  3'd2, 2'b01, 8'hFF, 64'h0000_0100_0000_0000, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 32'h0000_0200, 6'd10, 8'd1,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'h0000_0200_0000_0000};
`ifdef AXI_SCRATCH_DECERR_EN
    tbl[9]  = '{1'b0, 32'h0001_0000, 6'd11, 8'd1,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'h0};
    tbl[12] = '{1'b0, 32'h0000_0800, 6'd14, 8'd0,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'hAAAA};
`else
    tbl[9]  = '{1'b0, 32'h0001_0000, 6'd11, 8'd1,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'hFFFF_FFFF_0000_0000};
    tbl[12] = '{1'b0, 32'h0000_0800, 6'd14, 8'd0,  3'd3, 2'b01, 8'h00, 64'h0,                  1'b1, 64'hBBBB};
`endif
    tbl[10] = '{1'b1, 32'h0000_0800, 6'd12, 8'd0,  3'd3, 2'b01, 8'hFF, 64'hAAAA,               1'b0, 64'h0};
    tbl[11] = '{1'b1, 32'h0001_0800, 6'd13, 8'd0,  3'd3, 2'b01, 8'hFF, 64'hBBBB,               1'b0, 64'h0};
    tbl[13] = '{1'b1, 32'h0000_7FF8, 6'd15, 8'd1,  3'd3, 2'b10, 8'hFF, 64'h77,                 1'b0, 64'h0};
    tbl[14] = '{1'b0, 32'h0000_7FF8, 6'd16, 8'd1,  3'd3, 2'b11, 8'h00, 64'h0,                  1'b1, 64'h77};

    // Reset state and first-edge readiness
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1 chk("reset_outputs", ctl_vec(), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("aw_ready_before_edge", 64'(aw_ready), 64'd0);
    @(posedge clock);
    #1 chk("aw_ready_after_edge", 64'(aw_ready), 64'd1);
    @(negedge clock);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) do_write(tbl[i]);
      else           do_read(tbl[i], 1'b0);
    end

    // 256-beat write then read with r_ready toggling
    v = '{1'b1, 32'h0000_1000, 6'd40, 8'd255, 3'd3, 2'b01, 8'hFF, 64'h0100_0000_0000_0001, 1'b0, 64'h0};
    do_write(v);
    v = '{1'b0, 32'h0000_1000, 6'd41, 8'd255, 3'd3, 2'b01, 8'h00, 64'h0, 1'b1, 64'h0100_0000_0000_0001};
    do_read(v, 1'b1);

    // Reset during the second beat of a 4-beat write
    set_aw(32'h0000_3000, 6'd30, 8'd3, 3'd3, 2'b01);
    wait_aw();
    w_valid = 1'b1; w_data = 64'hDEAD; w_strb = 8'hFF;
    #1 chk("mid_w_ready", 64'(w_ready), 64'd1);
    @(negedge clock);
    w_data = 64'hBEEF;
    #2 reset_n = 1'b0;
    w_valid = 1'b0;
    #1 chk("mid_reset_outputs", ctl_vec(), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("mid_aw_ready_before_edge", 64'(aw_ready), 64'd0);
    @(posedge clock);
    #1 chk("mid_aw_ready_after_edge", 64'(aw_ready), 64'd1);
    any_b = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      #1 any_b = any_b | b_valid;
    end
    chk("no_b_after_reset", 64'(any_b), 64'd0);
    @(negedge clock);

    // Two successive AW/AR conflicts: write wins first, read second
    set_aw(32'h0000_2000, 6'd20, 8'd0, 3'd3, 2'b01);
    set_ar(32'h0000_0040, 6'd21, 8'd0, 3'd3, 2'b01);
    #1 chk("conflict1_grant", 64'({aw_ready, ar_ready}), 64'd2);
    wait_aw();
    w_beats(32'h0000_2000, 8'd0, 3'd3, 2'b01, 8'hFF, 64'h5555);
    b_wait(6'd20, 2'b00);
    set_aw(32'h0000_2008, 6'd22, 8'd0, 3'd3, 2'b01);
    #1 chk("conflict2_grant", 64'({aw_ready, ar_ready}), 64'd1);
    push_read(32'h0000_0040, 6'd21, 8'd0, 3'd3, 2'b01);
    wait_ar();
    r_collect(8'd0, 1'b0, 1'b1, 64'h11);
    wait_aw();
    w_beats(32'h0000_2008, 8'd0, 3'd3, 2'b01, 8'hFF, 64'h6666);
    b_wait(6'd22, 2'b00);
    v = '{1'b0, 32'h0000_2000, 6'd23, 8'd1, 3'd3, 2'b01, 8'h00, 64'h0, 1'b1, 64'h5555};
    do_read(v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_scratchpad_slave.md
AXI_SCRATCHPAD_SLAVE -- requirements
Module: axi_scratchpad_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 64-bit storage words (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 clock  input  1  sole clock; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 aw_valid/aw_ready  in/out  1/1; aw_addr in 32; aw_id in 6; aw_len in 8; aw_size in 3; aw_burst in 2.
REQ-006 w_valid/w_ready  in/out  1/1; w_data in 64; w_strb in 8; w_last in 1.
REQ-007 b_valid out 1; b_ready in 1; b_id out 6; b_resp out 2.
REQ-008 ar_valid/ar_ready  in/out  1/1; ar_addr in 32; ar_id in 6; ar_len in 8; ar_size in 3; ar_burst in 2.
REQ-009 r_valid out 1; r_ready in 1; r_id out 6; r_data out 64; r_resp out 2; r_last out 1.

Function
REQ-010 The block SHALL be an AXI4 responder for the memory-side master port, with one single-ported synchronous RAM and one transaction in flight.
REQ-011 FSM states SHALL be IDLE, WDATA, WRESP, RDATA; aw_ready and ar_ready high only in IDLE.
REQ-012 In IDLE with only aw_valid: accept AW, go WDATA; with only ar_valid: accept AR, go RDATA.
REQ-013 In IDLE with both valid, one handshake only: a priority bit SHALL alternate, write first after reset, toggling after every granted conflict.
REQ-014 Beat address: FIXED (2'b00) holds address; INCR (2'b01), WRAP and 2'b11 SHALL add (1 << size) per beat, 32-bit wrap; word index = (addr - BASE_ADDR) >> 3, modulo DEPTH_WORDS.
REQ-015 WDATA: w_ready high; each w handshake writes bytes enabled by w_strb the same cycle; beat counter (len+1 beats) is authoritative, w_last ignored; after final beat go WRESP next cycle.
REQ-016 WRESP: b_valid high with captured aw_id, b_resp OKAY unless REQ-024; hold until b_ready, then IDLE.
REQ-017 RDATA: first r_valid SHALL assert 2 cycles after the AR handshake; with r_ready held high beats SHALL be issued on consecutive cycles.
REQ-018 r_data/r_id/r_resp/r_last SHALL hold stable while r_valid && !r_ready; r_last high only on beat len+1; after its handshake go IDLE.
REQ-019 aw_len/ar_len 255 (256 beats) SHALL be supported without counter overflow.
REQ-020 Outputs not in use SHALL be 0 (r_data may hold last value).

Reset
REQ-021 On reset_n low: state IDLE; aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last = 0; b_resp, r_resp, b_id, r_id = 0; priority = write.
REQ-022 Reset mid-burst SHALL abandon the transaction without further responses; RAM contents are not reset.
REQ-023 aw_ready and ar_ready SHALL rise the first clock edge after reset_n deasserts.

Configuration
REQ-024 With AXI_SCRATCH_DECERR_EN defined: a burst whose start address lies outside [BASE_ADDR, BASE_ADDR + 8*DEPTH_WORDS) SHALL perform no RAM writes, return b_resp DECERR (2'b11) and r_resp DECERR on every read beat with r_data 0; beat counts and timing unchanged.
REQ-025 Without AXI_SCRATCH_DECERR_EN: all addresses alias modulo DEPTH_WORDS, responses always OKAY.

Verification
REQ-026 Write INCR len=3 addr 0x40 id 5 data 0x11..0x44 strb 0xFF, then read same -> b_id 5 OKAY; four r beats 0x11,0x22,0x33,0x44, r_last on 4th only, r_id 5.
REQ-027 Strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with strb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
REQ-028 aw_valid and ar_valid both high in IDLE twice in succession -> write granted first, read second; no simultaneous aw/ar handshakes.
REQ-029 Read len=255 with r_ready toggling every other cycle -> 256 beats, data stable during stalls, r_last on beat 256 only.
REQ-030 reset_n pulsed low in mid-WDATA beat 2 of 4 -> all valids/readies 0 immediately, aw_ready 1 one edge after release, no b_valid.
REQ-031 With AXI_SCRATCH_DECERR_EN, DEPTH_WORDS 4096, read len=1 at 0x0001_0000 -> two beats r_resp 2'b11, r_data 0; without macro -> word 0 data, OKAY.
